// File: rtl/ffm.sv
// GF(2^255-19) multiplier: MSB-first double-and-add over b, with every
// doubling and conditional add issued to one internal field adder.
module ffm_ffa (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] x,
  input  logic [254:0] y,
  output logic [254:0] sum,
  output logic         done
);
  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic [255:0] acc_q, acc_d;
  logic [254:0] sum_q, sum_d, red;
  logic [2:0]   cnt_q, cnt_d;
  logic         run_q, run_d, done_q, done_d;

  // Fixed 6-cycle issue-to-done latency; result reduced once into [0,p).
  always_comb begin
    acc_d  = acc_q;
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    red    = acc_q[254:0] - P;
    if (!run_q) begin
      if (start) begin
        acc_d = {1'b0, x} + {1'b0, y};
        cnt_d = 3'd1;
        run_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd5) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        sum_d  = (acc_q >= {1'b0, P}) ? red : acc_q[254:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign sum  = sum_q;
  assign done = done_q;
endmodule

module ffm (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic [254:0] out,
  output logic         done,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, DBL, DBL_W, ADD, ADD_W, NXT, FIN} state_t;

  state_t       state_q;
  logic [254:0] a_r_q, b_r_q, acc_q, out_q;
  logic [7:0]   idx_q;
  logic         done_q, busy_q;

  logic         fa_start, fa_done, op_sel;
  logic [254:0] fa_y, fa_sum;

  assign fa_start = (state_q == DBL) || (state_q == ADD);
  assign op_sel   = (state_q == ADD) || (state_q == ADD_W);
  assign fa_y     = op_sel ? a_r_q : acc_q;

  ffm_ffa u_ffa (
    .clk   (clk),
    .rst   (~rst_n),
    .start (fa_start),
    .x     (acc_q),
    .y     (fa_y),
    .sum   (fa_sum),
    .done  (fa_done)
  );

  // done/busy/out are set on entry to FIN so the pulse coincides with FIN,
  // where a new start cannot be sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_r_q   <= '0;
      b_r_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= 8'd254;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_r_q   <= a_i;
            b_r_q   <= b_i;
            acc_q   <= '0;
            idx_q   <= 8'd254;
            busy_q  <= 1'b1;
            state_q <= DBL;
          end
        end
        DBL: state_q <= DBL_W;
        DBL_W: if (fa_done) begin
          acc_q   <= fa_sum;
          state_q <= b_r_q[idx_q] ? ADD : NXT;
        end
        ADD: state_q <= ADD_W;
        ADD_W: if (fa_done) begin
          acc_q   <= fa_sum;
          state_q <= NXT;
        end
        NXT: begin
          if (idx_q == 8'd0) begin
            out_q   <= acc_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else begin
            idx_q   <= idx_q - 8'd1;
            state_q <= DBL;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ffm.sv
// Directed + random bench for ffm; expected products from a wide-integer
// a*b % p model, queued at issue and compared when done pulses.
module tb_ffm;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [254:0] a_i = '0, b_i = '0;
  logic [254:0] out;
  logic         done, busy;

  int checks = 0;
  int failures = 0;

  localparam logic [255:0] P_W = (256'd1 << 255) - 256'd19;
  logic [254:0] P;
  assign P = P_W[254:0];

  typedef struct { logic [254:0] v; int lat; } exp_t;
  exp_t sb[$];

  ffm dut (.clk(clk), .rst_n(rst_n), .start(start), .a_i(a_i), .b_i(b_i),
           .out(out), .done(done), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] pr;
    pr = {255'd0, a} * {255'd0, b};
    pr = pr % {255'd0, P_W[254:0]};
    return pr[254:0];
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[254:0];
  endfunction

  task automatic check_v(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle start is high; n counts cycles after it.
  task automatic run_op(input string tag, input logic [254:0] a, input logic [254:0] b,
                        input bit spam);
    exp_t e;
    int   n;
    bit   busy_ok;
    e.v   = mulmod(a, b);
    e.lat = 2041 + 7 * $countones(b);
    sb.push_back(e);
    @(negedge clk);
    a_i = a; b_i = b; start = 1'b1;
    @(negedge clk);
    n = 1;
    busy_ok = 1'b1;
    if (!spam) start = 1'b0;
    while (done !== 1'b1 && n < 5000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (spam) begin a_i = rnd255(); b_i = rnd255(); end
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check_i({tag, "_done_seen"}, int'(done), 1);
    check_i({tag, "_latency"}, n, e.lat);
    check_v({tag, "_out"}, out, e.v);
    check_i({tag, "_busy_during"}, int'(busy_ok), 1);
    check_i({tag, "_busy_at_done"}, int'(busy), 0);
    if (n >= 5000) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check_i({tag, "_done_width"}, int'(done), 0);
    check_i({tag, "_idle_after"}, int'(busy), 0);
    @(negedge clk);
    check_i({tag, "_no_restart"}, int'(busy), 0);
    check_v({tag, "_out_held"}, out, e.v);
  endtask

  initial begin
    logic [254:0] ra, rb, pw;
    int n;
    repeat (3) @(negedge clk);
    check_v("reset_out", out, '0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("one_x_one", 255'd1, 255'd1, 1'b0);
    run_op("pm1_sq", P - 255'd1, P - 255'd1, 1'b0);
    run_op("pm1_x2", P - 255'd1, 255'd2, 1'b0);
    pw = '0; pw[254] = 1'b1;
    run_op("wrap_19", 255'd2, pw, 1'b0);
    run_op("b_zero", 255'd12345, 255'd0, 1'b0);
    run_op("a_zero", 255'd0, {255{1'b1}}, 1'b0);
    run_op("start_spam", 255'd987654321, 255'h1234_5678_9abc_def0, 1'b1);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a_i = 255'd777; b_i = 255'd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 900) begin @(negedge clk); n++; end
    check_i("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_i("abort_done", int'(done), 0);
    check_i("abort_busy", int'(busy), 0);
    check_v("abort_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_abort", 255'd777, 255'd999, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = rnd255();
      if (ra >= P) ra = ra - P;
      rb = rnd255();
      run_op("random", ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
